// File: rtl/max_unpool_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lenet_pool_pkg
// Brief    : Shared pooling/unpooling types, default sizes and argmax codes.
// Revision : 1.0
// ============================================================================
package lenet_pool_pkg;

    localparam int BITWIDTH = 8;
    localparam int IN_DIM   = 14;
    localparam int CHANNELS = 2;

    typedef logic signed [BITWIDTH-1:0] pixel_t;
    typedef logic [1:0]                 idx_t;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        REPEAT = 1'b1
    } unpool_state_e;

    // Argmax position inside a 2x2 window, as produced by the max-pool stage.
    localparam idx_t IDX_TL = 2'd0;
    localparam idx_t IDX_BL = 2'd1;
    localparam idx_t IDX_TR = 2'd2;
    localparam idx_t IDX_BR = 2'd3;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/max_unpool_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : max_unpool_stream_if
// Brief    : Pooled-pixel input stream and upsampled output stream bundle.
//            UNPOOL_INDEX_EN adds the argmax index lane on the input side.
// Revision : 1.0
// ============================================================================
interface max_unpool_stream_if #(
    parameter int BITWIDTH = lenet_pool_pkg::BITWIDTH
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [BITWIDTH-1:0] in_data;
`ifdef UNPOOL_INDEX_EN
    logic [1:0]                 in_idx;
`endif
    logic                       out_valid;
    logic                       out_ready;
    logic signed [BITWIDTH-1:0] out_data;
    logic                       out_eol;
    logic                       out_eoc;
    logic                       out_eof;

`ifdef UNPOOL_INDEX_EN
    modport master (
        output in_valid, in_data, in_idx, out_ready,
        input  in_ready, out_valid, out_data, out_eol, out_eoc, out_eof
    );
    modport slave (
        input  in_valid, in_data, in_idx, out_ready,
        output in_ready, out_valid, out_data, out_eol, out_eoc, out_eof
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_eol, out_eoc, out_eof
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_eol, out_eoc, out_eof
    );
`endif
endinterface
`default_nettype wire

// File: rtl/max_unpool_stream_row_buf.sv
`default_nettype none
// ============================================================================
// Module   : unpool_row_buf
// Brief    : One pooled row of pixels (plus argmax index under UNPOOL_INDEX_EN),
//            written while the even output row streams, read for the odd row.
// Revision : 1.0
// ============================================================================
module unpool_row_buf #(
    parameter int BITWIDTH = lenet_pool_pkg::BITWIDTH,
    parameter int IN_DIM   = lenet_pool_pkg::IN_DIM,
    parameter int ADDR_W   = lenet_pool_pkg::clog2_min1(IN_DIM)
) (
    input  wire logic                clk,
    input  wire logic                wr_en_i,
    input  wire logic [ADDR_W-1:0]   wr_addr_i,
    input  wire logic [BITWIDTH-1:0] wr_data_i,
`ifdef UNPOOL_INDEX_EN
    input  wire logic [1:0]          wr_idx_i,
    output logic [1:0]               rd_idx_o,
`endif
    input  wire logic [ADDR_W-1:0]   rd_addr_i,
    output logic [BITWIDTH-1:0]      rd_data_o
);
    import lenet_pool_pkg::*;

    // Contents are don't-care after reset, so the array carries no reset.
    logic [BITWIDTH-1:0] data_q [IN_DIM];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = data_q[rd_addr_i];

`ifdef UNPOOL_INDEX_EN
    idx_t idx_q [IN_DIM];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            idx_q[wr_addr_i] <= wr_idx_i;
        end
    end

    assign rd_idx_o = idx_q[rd_addr_i];
`endif

endmodule
`default_nettype wire

// File: rtl/max_unpool_stream.sv
`default_nettype none
// ============================================================================
// Module   : max_unpool_stream
// Brief    : Streaming 2x2 unpool: each pooled row is emitted twice horizontally
//            (even row, live) then replayed from a row buffer (odd row).
//            UNPOOL_INDEX_EN selects true max-unpool (value at argmax only).
// Revision : 1.0
// ============================================================================
module max_unpool_stream #(
    parameter int BITWIDTH = lenet_pool_pkg::BITWIDTH,
    parameter int IN_DIM   = lenet_pool_pkg::IN_DIM,
    parameter int CHANNELS = lenet_pool_pkg::CHANNELS
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    max_unpool_stream_if.slave  stream
);
    import lenet_pool_pkg::*;

    localparam int COL_W = clog2_min1(IN_DIM);
    localparam int CH_W  = clog2_min1(CHANNELS);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_DIM - 1);
    localparam logic [COL_W-1:0] LAST_ROW = COL_W'(IN_DIM - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);

    unpool_state_e         state_q, state_d;
    logic                  run_q;
    logic                  out_valid_q, out_valid_d;
    logic                  phase_q, phase_d;
    logic [COL_W-1:0]      out_col_q, out_col_d;
    logic [COL_W-1:0]      in_col_q, in_col_d;
    logic [COL_W-1:0]      row_q, row_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [BITWIDTH-1:0]   pix_q, pix_d;
    logic [BITWIDTH-1:0]   buf_pix;

    logic                  in_ready;
    logic                  in_fire;
    logic                  out_fire;
    logic                  is_repeat;
    logic                  row_end_beat;
    logic [BITWIDTH-1:0]   src_pix;
    logic [BITWIDTH-1:0]   out_data;

`ifdef UNPOOL_INDEX_EN
    logic [1:0]            idx_q, idx_d;
    logic [1:0]            buf_idx;
    logic [1:0]            src_idx;
`endif

    assign is_repeat    = (state_q == REPEAT);
    assign row_end_beat = phase_q && (out_col_q == LAST_COL);
    assign out_fire     = out_valid_q && stream.out_ready;

    // A new pixel may enter while the phase-1 beat leaves, except on the last
    // column where the odd row must be replayed first.
    assign in_ready = run_q && !is_repeat &&
                      (!out_valid_q || (phase_q && stream.out_ready && (out_col_q != LAST_COL)));
    assign in_fire  = stream.in_valid && in_ready;

    unpool_row_buf #(
        .BITWIDTH (BITWIDTH),
        .IN_DIM   (IN_DIM),
        .ADDR_W   (COL_W)
    ) u_row_buf (
        .clk       (clk),
        .wr_en_i   (in_fire),
        .wr_addr_i (in_col_q),
        .wr_data_i (stream.in_data),
`ifdef UNPOOL_INDEX_EN
        .wr_idx_i  (stream.in_idx),
        .rd_idx_o  (buf_idx),
`endif
        .rd_addr_i (out_col_q),
        .rd_data_o (buf_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            run_q       <= 1'b0;
            out_valid_q <= 1'b0;
            phase_q     <= 1'b0;
            out_col_q   <= '0;
            in_col_q    <= '0;
            row_q       <= '0;
            ch_q        <= '0;
            pix_q       <= '0;
`ifdef UNPOOL_INDEX_EN
            idx_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            out_valid_q <= out_valid_d;
            phase_q     <= phase_d;
            out_col_q   <= out_col_d;
            in_col_q    <= in_col_d;
            row_q       <= row_d;
            ch_q        <= ch_d;
            pix_q       <= pix_d;
`ifdef UNPOOL_INDEX_EN
            idx_q       <= idx_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        phase_d     = phase_q;
        out_col_d   = out_col_q;
        in_col_d    = in_col_q;
        row_d       = row_q;
        ch_d        = ch_q;
        pix_d       = pix_q;
`ifdef UNPOOL_INDEX_EN
        idx_d       = idx_q;
`endif
        case (state_q)
            FILL: begin
                if (out_fire) begin
                    phase_d = ~phase_q;
                    if (row_end_beat) begin
                        state_d   = REPEAT;
                        out_col_d = '0;
                    end else if (phase_q) begin
                        out_valid_d = 1'b0;
                    end
                end
                if (in_fire) begin
                    out_valid_d = 1'b1;
                    phase_d     = 1'b0;
                    pix_d       = stream.in_data;
                    out_col_d   = in_col_q;
                    in_col_d    = (in_col_q == LAST_COL) ? '0 : in_col_q + COL_W'(1);
`ifdef UNPOOL_INDEX_EN
                    idx_d       = stream.in_idx;
`endif
                end
            end
            REPEAT: begin
                if (out_fire) begin
                    phase_d = ~phase_q;
                    if (row_end_beat) begin
                        state_d     = FILL;
                        out_valid_d = 1'b0;
                        out_col_d   = '0;
                        if (row_q == LAST_ROW) begin
                            row_d = '0;
                            ch_d  = (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
                        end else begin
                            row_d = row_q + COL_W'(1);
                        end
                    end else if (phase_q) begin
                        out_col_d = out_col_q + COL_W'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign src_pix = is_repeat ? buf_pix : pix_q;

`ifdef UNPOOL_INDEX_EN
    // The idx code is {column bit, row bit} of the window, matching {phase, odd row}.
    assign src_idx  = is_repeat ? buf_idx : idx_q;
    assign out_data = (src_idx == {phase_q, is_repeat}) ? src_pix : '0;
`else
    assign out_data = src_pix;
`endif

    assign stream.in_ready  = in_ready;
    assign stream.out_valid = out_valid_q;
    assign stream.out_data  = out_data;
    assign stream.out_eol   = out_valid_q && row_end_beat;
    assign stream.out_eoc   = out_valid_q && row_end_beat && is_repeat && (row_q == LAST_ROW);
    assign stream.out_eof   = out_valid_q && row_end_beat && is_repeat && (row_q == LAST_ROW) &&
                              (ch_q == LAST_CH);

endmodule
`default_nettype wire

// File: tb/tb_max_unpool_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_unpool_stream
// Brief    : Scoreboard bench for max_unpool_stream (both UNPOOL_INDEX_EN builds).
// Revision : 1.0
// ============================================================================
module tb_max_unpool_stream;
    localparam int BW          = 8;
    localparam int IN          = 14;
    localparam int CH          = 2;
    localparam int OD          = 2 * IN;
    localparam int FRAME_BEATS = CH * OD * OD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    max_unpool_stream_if #(.BITWIDTH(BW)) bus ();

    max_unpool_stream #(
        .BITWIDTH (BW),
        .IN_DIM   (IN),
        .CHANNELS (CH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .stream (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int bcnt  = 0;
    bit rand_ready = 1'b0;
    bit gap_mode   = 1'b0;
    bit abort      = 1'b0;

    logic [BW+2:0]        sb [$];
    logic signed [BW-1:0] fr [CH][IN][IN];
    logic [1:0]           fi [CH][IN][IN];

    task automatic fill_frame(input int kind);
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < IN; r++)
                for (int j = 0; j < IN; j++) begin
                    if (kind == 0)
                        fr[c][r][j] = BW'((c == 0) ? (IN * r + j) : (-128 + IN * r + j));
                    else
                        fr[c][r][j] = BW'(r * 37 - j * 11 + c * 64 - 90);
                    fi[c][r][j] = 2'((r + j + c + kind) % 4);
                end
`ifdef UNPOOL_INDEX_EN
        fr[0][0][0] = 8'sd5;
        fi[0][0][0] = 2'd3;
`endif
    endtask

    task automatic push_frame();
        logic [BW-1:0] v;
        logic eol, eoc, eof;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < IN; r++)
                for (int h = 0; h < 2; h++)
                    for (int j = 0; j < IN; j++)
                        for (int p = 0; p < 2; p++) begin
                            v = fr[c][r][j];
`ifdef UNPOOL_INDEX_EN
                            if (fi[c][r][j] != 2'(p * 2 + h)) v = '0;
`endif
                            eol = ((2 * j + p) == OD - 1);
                            eoc = eol && ((2 * r + h) == OD - 1);
                            eof = eoc && (c == CH - 1);
                            sb.push_back({eof, eoc, eol, v});
                        end
    endtask

    task automatic drive_frame();
        bit ok;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < IN; r++)
                for (int j = 0; j < IN; j++) begin
                    if (abort) return;
                    if (gap_mode && ($urandom_range(0, 3) == 0))
                        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                    bus.in_valid = 1'b1;
                    bus.in_data  = fr[c][r][j];
`ifdef UNPOOL_INDEX_EN
                    bus.in_idx   = fi[c][r][j];
`endif
                    ok = 1'b0;
                    for (int t = 0; t < 4000; t++) begin
                        @(negedge clk);
                        if (abort) break;
                        if (bus.in_ready) begin ok = 1'b1; break; end
                    end
                    @(posedge clk); #1;
                    bus.in_valid = 1'b0;
                    if (!ok && !abort) begin
                        total++; bad++;
                        $display("FAIL in_accept_timeout: pixel c%0d r%0d j%0d got no in_ready, want in_ready=1", c, r, j);
                        return;
                    end
                end
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if (bus.out_valid || bus.out_eol || bus.out_eoc || bus.out_eof || bus.in_ready ||
            (bus.out_data != 0)) begin
            bad++;
            $display("FAIL %s: got valid=%b data=%0d eol=%b eoc=%b eof=%b in_ready=%b, want all 0",
                     name, bus.out_valid, bus.out_data, bus.out_eol, bus.out_eoc, bus.out_eof, bus.in_ready);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 20000 && sb.size() != 0; t++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d beats still expected, want 0", name, sb.size());
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every transferring beat.
    initial begin
        logic [BW+2:0] exp_v, act_v, held;
        bit stalled = 1'b0;
        int pos;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                act_v = {bus.out_eof, bus.out_eoc, bus.out_eol, bus.out_data};
                pos   = bcnt % FRAME_BEATS;
                if (bus.out_valid && bus.in_valid && (((pos / OD) % 2) == 1)) begin
                    total++;
                    if (bus.in_ready) begin
                        bad++;
                        $display("FAIL repeat_in_ready: beat %0d got in_ready=1, want 0", pos);
                    end
                end
                if (stalled) begin
                    total++;
                    if (!bus.out_valid || (act_v != held)) begin
                        bad++;
                        $display("FAIL stall_hold: got valid=%b beat=%h, want valid=1 beat=%h",
                                 bus.out_valid, act_v, held);
                    end
                end
                stalled = bus.out_valid && !bus.out_ready;
                held    = act_v;
                if (bus.out_valid && bus.out_ready) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL extra_beat: got beat %h, want no beat", act_v);
                    end else begin
                        exp_v = sb.pop_front();
                        if (act_v != exp_v) begin
                            bad++;
                            $display("FAIL beat_%0d: got eof/eoc/eol/data=%b%b%b/%0d, want %b%b%b/%0d",
                                     pos, act_v[BW+2], act_v[BW+1], act_v[BW], $signed(act_v[BW-1:0]),
                                     exp_v[BW+2], exp_v[BW+1], exp_v[BW], $signed(exp_v[BW-1:0]));
                        end
                    end
                    bcnt++;
                end
            end
        end
    end

    initial begin
        int base;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
`ifdef UNPOOL_INDEX_EN
        bus.in_idx   = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Ramp, full-rate output.
        fill_frame(0);
        push_frame();
        drive_frame();
        wait_drain("drain_ramp");

        // Random backpressure and input bubbles.
        rand_ready = 1'b1;
        gap_mode   = 1'b1;
        fill_frame(1);
        push_frame();
        drive_frame();
        wait_drain("drain_random");
        rand_ready = 1'b0;
        gap_mode   = 1'b0;

        // Reset asserted mid-frame, then a clean frame from (ch0,row0,col0).
        fill_frame(0);
        push_frame();
        base = bcnt;
        fork
            drive_frame();
            begin
                for (int t = 0; t < 5000 && (bcnt - base) < 300; t++) @(negedge clk);
                @(posedge clk); #1;
                abort = 1'b1;
                rst_n = 1'b0;
            end
        join
        sb.delete();
        bcnt = 0;
        @(negedge clk);
        check_reset_outputs("mid_frame_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        abort = 1'b0;
        bus.in_valid = 1'b0;

        fill_frame(1);
        push_frame();
        drive_frame();
        wait_drain("drain_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
